// File: rtl/mode_select_fsm_if.sv
// -----------------------------------------------------------------------------
// mode_select_fsm_if
//   Bundles the button inputs, the countdown handshake and the selector
//   outputs of mode_select_fsm into one interface.
//
//   Signals
//     buttons_i          NUM_MODES  raw, asynchronous button levels (1 = pressed)
//     countdown_done_i   1          1-cycle pulse from the countdown at zero
//     mode_o             MODE_W     selected mode, 0 = idle
//     countdown_start_o  1          1-cycle pulse: start the countdown in mode_o
//     countdown_abort_o  1          1-cycle pulse: countdown cancelled
//     state_o            2          debug state: 00 IDLE, 01 START, 10 RUN
//
//   Modports
//     master  board / countdown side: drives buttons and done, observes outputs
//     slave   the selector itself
// -----------------------------------------------------------------------------
interface mode_select_fsm_if #(
    parameter int NUM_MODES = 4
);
    localparam int MODE_W = $clog2(NUM_MODES);

    logic [NUM_MODES-1:0] buttons_i;
    logic                 countdown_done_i;
    logic [MODE_W-1:0]    mode_o;
    logic                 countdown_start_o;
    logic                 countdown_abort_o;
    logic [1:0]           state_o;

    modport master (
        output buttons_i,
        output countdown_done_i,
        input  mode_o,
        input  countdown_start_o,
        input  countdown_abort_o,
        input  state_o
    );

    modport slave (
        input  buttons_i,
        input  countdown_done_i,
        output mode_o,
        output countdown_start_o,
        output countdown_abort_o,
        output state_o
    );
endinterface

// File: rtl/mode_select_fsm.sv
// -----------------------------------------------------------------------------
// mode_select_fsm
//   Countdown front end: synchronises and debounces NUM_MODES push buttons,
//   turns each debounced rising level into a one-cycle press event, resolves
//   simultaneous events by priority (highest index wins) and sequences the
//   countdown: start pulse, run, then abort (IDLE button) or done.
//   Button k selects mode NUM_MODES-1-k; button NUM_MODES-1 is IDLE/abort.
//
//   Ports
//     clk_i    in  system clock, rising edge
//     rst_n_i  in  asynchronous active-low reset
//     bus      mode_select_fsm_if.slave (buttons, done, mode/start/abort/state)
//
//   Latency from the first edge sampling a clean raw rise to the start pulse
//   is SYNC_STAGES + DEBOUNCE_CYCLES + 1 edges: SYNC_STAGES to cross the
//   synchroniser, DEBOUNCE_CYCLES to qualify the level (the press event is
//   registered with the stable level), one more for the registered FSM output.
// -----------------------------------------------------------------------------
module mode_select_fsm #(
    parameter int NUM_MODES       = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int SYNC_STAGES     = 2
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    mode_select_fsm_if.slave  bus
);
    localparam int MODE_W   = $clog2(NUM_MODES);
    localparam int CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int IDLE_BTN = NUM_MODES - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_START = 2'b01,
        ST_RUN   = 2'b10
    } state_e;

    // -------------------------------------------------------------------------
    // Synchroniser and debouncer, one lane per button
    // -------------------------------------------------------------------------
    logic [SYNC_STAGES-1:0] sync_q [NUM_MODES];
    logic [CNT_W-1:0]       cnt_q  [NUM_MODES];
    logic [NUM_MODES-1:0]   synced;
    logic [NUM_MODES-1:0]   stable_q;
    logic [NUM_MODES-1:0]   press_q;

    // NOTE: every variable written in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        synced = '0;
        for (int k = 0; k < NUM_MODES; k++) begin
            synced[k] = sync_q[k][SYNC_STAGES-1];
        end
    end

    // The counter tracks how many consecutive clocks the synced level has
    // disagreed with the stable level; any agreement clears it. On the
    // qualifying clock the stable level flips and, for a 0->1 flip, press_q
    // carries a one-cycle event aligned with the new stable level.
    // NOTE: these arrays are ordinary per-button flops, not RAM, so they are
    // cleared by the async reset like every other register here.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int k = 0; k < NUM_MODES; k++) begin
                sync_q[k] <= '0;
                cnt_q[k]  <= '0;
            end
            stable_q <= '0;
            press_q  <= '0;
        end else begin
            // NOTE: state is updated with non-blocking assignments so every
            // flop samples the values from before this edge.
            for (int k = 0; k < NUM_MODES; k++) begin
                sync_q[k]  <= {sync_q[k][SYNC_STAGES-2:0], bus.buttons_i[k]};
                press_q[k] <= 1'b0;
                if (synced[k] == stable_q[k]) begin
                    cnt_q[k] <= '0;
                end else if (cnt_q[k] == CNT_LAST) begin
                    cnt_q[k]    <= '0;
                    stable_q[k] <= synced[k];
                    press_q[k]  <= synced[k];
                end else begin
                    cnt_q[k] <= cnt_q[k] + CNT_W'(1);
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Priority resolution: the highest-index event wins. Because the IDLE
    // button has the highest index, an IDLE event always wins when present.
    // -------------------------------------------------------------------------
    logic              win_valid;
    logic [MODE_W-1:0] win_idx;
    logic [MODE_W-1:0] win_mode;
    logic              idle_evt;

    always_comb begin
        win_valid = 1'b0;
        win_idx   = '0;
        for (int k = 0; k < NUM_MODES; k++) begin
            if (press_q[k]) begin
                win_valid = 1'b1;
                win_idx   = MODE_W'(k);
            end
        end
    end

    assign idle_evt = press_q[IDLE_BTN];
    assign win_mode = MODE_W'(IDLE_BTN) - win_idx;

    // -------------------------------------------------------------------------
    // Sequencing FSM. All outputs are registered: start_q is set on the edge
    // that enters START, so it is high exactly while state_q == ST_START.
    // -------------------------------------------------------------------------
    state_e            state_q, state_d;
    logic [MODE_W-1:0] mode_q,  mode_d;
    logic              start_q, start_d;
    logic              abort_q, abort_d;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
            mode_q  <= '0;
            start_q <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            mode_q  <= mode_d;
            start_q <= start_d;
            abort_q <= abort_d;
        end
    end

    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        start_d = 1'b0;
        abort_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // An IDLE-button win and countdown_done_i are both no-ops here.
                if (win_valid && !idle_evt) begin
                    mode_d  = win_mode;
                    start_d = 1'b1;
                    state_d = ST_START;
                end
            end
            ST_START: begin
                // Events arriving during the start cycle are dropped.
                state_d = ST_RUN;
            end
            ST_RUN: begin
                // Abort takes precedence over done in the same cycle; other
                // mode buttons cannot reselect mid-countdown.
                if (idle_evt) begin
                    abort_d = 1'b1;
                    mode_d  = '0;
                    state_d = ST_IDLE;
                end else if (bus.countdown_done_i) begin
                    mode_d  = '0;
                    state_d = ST_IDLE;
                end
            end
            default: begin
                // Unused encoding 2'b11: fall back to a clean idle.
                mode_d  = '0;
                state_d = ST_IDLE;
            end
        endcase
    end

    assign bus.mode_o            = mode_q;
    assign bus.countdown_start_o = start_q;
    assign bus.countdown_abort_o = abort_q;
    assign bus.state_o           = state_q;

    // Start and abort are mutually exclusive, and start never lasts two cycles.
    a_start_abort_excl : assert property (
        @(posedge clk_i) disable iff (!rst_n_i) !(start_q && abort_q));
    a_start_single : assert property (
        @(posedge clk_i) disable iff (!rst_n_i) start_q |=> !start_q);

endmodule

// File: tb/tb_mode_select_fsm.sv
// -----------------------------------------------------------------------------
// tb_mode_select_fsm
//   Bench for mode_select_fsm with NUM_MODES=4, DEBOUNCE_CYCLES=4,
//   SYNC_STAGES=2 (start latency L=7). Every clock edge is compared against a
//   behavioural model that debounces by looking at a window of past raw
//   samples and sequences the countdown with plain flags. A table of button
//   patterns and a few hand-written sequences check the corner cases with
//   fixed expected values; a randomized run closes it out.
// -----------------------------------------------------------------------------
module tb_mode_select_fsm;
    localparam int N = 4;
    localparam int D = 4;
    localparam int S = 2;
    localparam int L = S + D + 1;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    mode_select_fsm_if #(.NUM_MODES(N)) bus ();

    mode_select_fsm #(
        .NUM_MODES      (N),
        .DEBOUNCE_CYCLES(D),
        .SYNC_STAGES    (S)
    ) dut (
        .clk_i  (clk),
        .rst_n_i(rst_n),
        .bus    (bus.slave)
    );

    int    tests_run    = 0;
    int    tests_failed = 0;
    string tag          = "init";

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        tests_run++;
        if (actual !== expected) begin
            tests_failed++;
            $display("FAIL %s/%s: got %0d, expected %0d (t=%0t)",
                     tag, name, actual, expected, $time);
        end
    endtask

    // ------------------------------------------------------------------------
    // Behavioural model
    // ------------------------------------------------------------------------
    logic [N-1:0] m_hist[$];   // raw samples, index 0 = newest edge
    logic [N-1:0] m_stable;
    logic [N-1:0] m_evt;       // events usable at the next edge
    int           m_mode;
    bit           m_starting, m_running, m_start, m_abort;

    task automatic model_reset();
        m_hist.delete();
        repeat (S + D) m_hist.push_back('0);
        m_stable   = '0;
        m_evt      = '0;
        m_mode     = 0;
        m_starting = 1'b0;
        m_running  = 1'b0;
        m_start    = 1'b0;
        m_abort    = 1'b0;
    endtask

    task automatic model_step(input logic [N-1:0] raw, input logic done);
        int           top;
        logic [N-1:0] new_evt;
        bit           all_diff;
        top = -1;
        for (int k = 0; k < N; k++) if (m_evt[k]) top = k;
        m_start = 1'b0;
        m_abort = 1'b0;
        if (m_starting) begin
            m_starting = 1'b0;
            m_running  = 1'b1;
        end else if (m_running) begin
            if (top == N - 1) begin
                m_abort   = 1'b1;
                m_mode    = 0;
                m_running = 1'b0;
            end else if (done) begin
                m_mode    = 0;
                m_running = 1'b0;
            end
        end else if (top >= 0 && top < N - 1) begin
            m_mode     = N - 1 - top;
            m_starting = 1'b1;
            m_start    = 1'b1;
        end
        // A level is accepted once the D samples that have crossed the
        // synchroniser (S edges old and older) all disagree with it.
        m_hist.push_front(raw);
        void'(m_hist.pop_back());
        new_evt = '0;
        for (int k = 0; k < N; k++) begin
            all_diff = 1'b1;
            for (int j = S; j < S + D; j++)
                if (m_hist[j][k] == m_stable[k]) all_diff = 1'b0;
            if (all_diff) begin
                if (!m_stable[k]) new_evt[k] = 1'b1;
                m_stable[k] = ~m_stable[k];
            end
        end
        m_evt = new_evt;
    endtask

    task automatic compare_model();
        int exp_state;
        exp_state = m_starting ? 1 : (m_running ? 2 : 0);
        check("mode",  32'(bus.mode_o),            m_mode);
        check("start", 32'(bus.countdown_start_o), 32'(m_start));
        check("abort", 32'(bus.countdown_abort_o), 32'(m_abort));
        check("state", 32'(bus.state_o),           exp_state);
    endtask

    // One rising edge: advance the model with the inputs the DUT sees, then
    // compare shortly after the edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) model_step(bus.buttons_i, bus.countdown_done_i);
        else       model_reset();
        #1;
        compare_model();
    endtask

    // Asserts reset mid-cycle (outputs must clear at once), holds it for a
    // few edges with the given buttons applied, releases it on a falling edge.
    task automatic apply_reset(input logic [N-1:0] hold_buttons, input int cycles);
        #2;
        rst_n                = 1'b0;
        bus.countdown_done_i = 1'b0;
        bus.buttons_i        = hold_buttons;
        model_reset();
        #1;
        check("rst_mode",  32'(bus.mode_o),            0);
        check("rst_start", 32'(bus.countdown_start_o), 0);
        check("rst_abort", 32'(bus.countdown_abort_o), 0);
        check("rst_state", 32'(bus.state_o),           0);
        repeat (cycles) tick();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Applies a button pattern for a number of edges and reports the
    // 1-based edge of the first start/abort pulse and the pulse counts.
    task automatic run_hold(input logic [N-1:0] b, input int cycles,
                            output int first_start, output int n_start,
                            output int first_abort, output int n_abort);
        bus.buttons_i = b;
        first_start = 0; n_start = 0; first_abort = 0; n_abort = 0;
        for (int i = 1; i <= cycles; i++) begin
            tick();
            if (bus.countdown_start_o) begin
                n_start++;
                if (first_start == 0) first_start = i;
            end
            if (bus.countdown_abort_o) begin
                n_abort++;
                if (first_abort == 0) first_abort = i;
            end
        end
    endtask

    typedef struct {
        logic [N-1:0] buttons;
        int           exp_mode;
        int           exp_first;   // edge of the start pulse, 0 = none
        int           exp_starts;
        int           exp_state;
    } vec_t;

    vec_t vecs[8];

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int           fs, ns, fa, na;
        int           total_starts, total_aborts;
        logic [N-1:0] b;
        int           k;

        bus.buttons_i        = '0;
        bus.countdown_done_i = 1'b0;
        model_reset();

        vecs[0] = '{4'b0100, 1, L, 1, 2};
        vecs[1] = '{4'b0010, 2, L, 1, 2};
        vecs[2] = '{4'b0001, 3, L, 1, 2};
        vecs[3] = '{4'b0011, 2, L, 1, 2};   // button 1 beats button 0
        vecs[4] = '{4'b0110, 1, L, 1, 2};
        vecs[5] = '{4'b1000, 0, 0, 0, 0};   // IDLE button in IDLE: no effect
        vecs[6] = '{4'b1010, 0, 0, 0, 0};   // IDLE wins priority: no effect
        vecs[7] = '{4'b0000, 0, 0, 0, 0};

        // Table-driven: clean presses from reset, held for 20 edges.
        for (int i = 0; i < 8; i++) begin
            tag = $sformatf("vec%0d", i);
            apply_reset('0, 2);
            run_hold(vecs[i].buttons, 20, fs, ns, fa, na);
            check("first_start", fs, vecs[i].exp_first);
            check("n_start",     ns, vecs[i].exp_starts);
            check("n_abort",     na, 0);
            check("mode",  32'(bus.mode_o),  vecs[i].exp_mode);
            check("state", 32'(bus.state_o), vecs[i].exp_state);
        end

        // Bouncing button 1: toggles every 2 edges for 12, then held.
        tag = "bounce";
        apply_reset('0, 2);
        total_starts = 0;
        for (int i = 0; i < 6; i++) begin
            run_hold((i % 2 == 0) ? 4'b0010 : 4'b0000, 2, fs, ns, fa, na);
            total_starts += ns;
        end
        run_hold(4'b0010, 20, fs, ns, fa, na);
        total_starts += ns;
        check("n_start", total_starts, 1);
        check("mode", 32'(bus.mode_o), 2);

        // RUN: another mode button is ignored, then IDLE aborts.
        tag = "run_abort";
        apply_reset('0, 2);
        run_hold(4'b0010, 20, fs, ns, fa, na);
        run_hold(4'b0001, 20, fs, ns, fa, na);
        check("ign_n_start", ns, 0);
        check("ign_n_abort", na, 0);
        check("ign_mode",  32'(bus.mode_o),  2);
        check("ign_state", 32'(bus.state_o), 2);
        run_hold(4'b1000, 20, fs, ns, fa, na);
        check("first_abort", fa, L);
        check("n_abort",     na, 1);
        check("n_start",     ns, 0);
        check("mode",  32'(bus.mode_o),  0);
        check("state", 32'(bus.state_o), 0);

        // RUN: countdown_done_i returns to IDLE without an abort pulse.
        tag = "run_done";
        apply_reset('0, 2);
        run_hold(4'b0100, 20, fs, ns, fa, na);
        bus.countdown_done_i = 1'b1;
        tick();
        bus.countdown_done_i = 1'b0;
        check("abort", 32'(bus.countdown_abort_o), 0);
        check("mode",  32'(bus.mode_o),            0);
        check("state", 32'(bus.state_o),           0);
        run_hold(4'b0000, 10, fs, ns, fa, na);
        check("n_abort", na, 0);

        // RUN: IDLE event and done on the same edge count as an abort.
        tag = "done_and_idle";
        run_hold(4'b0010, 20, fs, ns, fa, na);
        check("state_run", 32'(bus.state_o), 2);
        bus.buttons_i = 4'b1010;
        repeat (L - 1) tick();
        bus.countdown_done_i = 1'b1;
        tick();
        bus.countdown_done_i = 1'b0;
        check("abort", 32'(bus.countdown_abort_o), 1);
        check("mode",  32'(bus.mode_o),            0);
        check("state", 32'(bus.state_o),           0);

        // RUN: reset mid-cycle is silent; the still-held button is a new press.
        tag = "run_reset";
        run_hold(4'b0000, 10, fs, ns, fa, na);
        run_hold(4'b0100, 20, fs, ns, fa, na);
        check("state_run", 32'(bus.state_o), 2);
        apply_reset(4'b0100, 3);
        run_hold(4'b0100, 20, fs, ns, fa, na);
        check("held_first_start", fs, L);
        check("held_n_abort",     na, 0);
        check("held_mode", 32'(bus.mode_o), 1);

        // Randomized run against the model.
        tag = "rand";
        apply_reset('0, 2);
        b = '0;
        total_starts = 0;
        total_aborts = 0;
        for (int c = 0; c < 3000; c++) begin
            if ($urandom_range(0, 7) == 0) begin
                k    = $urandom_range(0, N - 1);
                b[k] = ~b[k];
            end
            bus.buttons_i        = b;
            bus.countdown_done_i = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 499) == 0) apply_reset(b, 2);
            tick();
            if (bus.countdown_start_o) total_starts++;
            if (bus.countdown_abort_o) total_aborts++;
        end
        bus.countdown_done_i = 1'b0;
        check("saw_starts", 32'(total_starts > 0), 1);
        check("saw_aborts", 32'(total_aborts > 0), 1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
